// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock for the 5-stage CPU (load-use bubbles, memory freeze, branch squash, stall counter)
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_rs1/id_rs2(+_used)       ID-stage source registers and their use flags
//   ex_rd, ex_is_load           EX-stage destination and load flag
//   ex_branch_taken             taken branch/jump resolved in EX
//   mem_req, mem_ready          data-memory handshake in MEM
//   pc_hold, if_id_hold, id_ex_hold, ex_mem_hold   pipeline register holds
//   id_ex_bubble, if_id_flush   NOP insertion into ID/EX and IF/ID
//   busy                        a multi-cycle load-use stall is in progress
//   stall_cycles                saturating count of pc_hold cycles
module hazard_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             ex_mem_hold,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic RUN      = 1'b0;
  localparam logic LU_STALL = 1'b1;
  logic             state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             lu_hit, mem_stall, in_lu, br_act, lu_act;
  assign lu_hit    = ex_is_load & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & ~mem_ready;
  assign in_lu     = state_q == LU_STALL;
  // While in LU_STALL EX holds a bubble, so branch and load-use inputs are stale.
  assign br_act    = ~in_lu & ex_branch_taken;
  assign lu_act    = ~in_lu & ~ex_branch_taken & lu_hit;
  // Outputs are gated by rst_n so they drop the instant reset asserts.
  assign pc_hold      = rst_n & (mem_stall | in_lu | lu_act);
  assign if_id_hold   = pc_hold;
  assign id_ex_hold   = rst_n & mem_stall;
  assign ex_mem_hold  = rst_n & mem_stall;
  assign id_ex_bubble = rst_n & ~mem_stall & (in_lu | br_act | lu_act);
  assign if_id_flush  = rst_n & ~mem_stall & br_act;
  assign busy         = rst_n & in_lu;
  assign stall_cycles = stall_cycles_q;
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    if (!mem_stall && in_lu) begin
      lu_cnt_d = lu_cnt_q - 3'd1;
      state_d  = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
    end else if (!mem_stall && lu_act && LOAD_LAT > 1) begin
      state_d  = LU_STALL;
      lu_cnt_d = 3'(LOAD_LAT - 1);
    end
    stall_cycles_d = (pc_hold && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      lu_cnt_q       <= 3'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      lu_cnt_q       <= lu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule
